// File: rtl/rf_write_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter_pkg
// Shared constants for the register-file write-port arbiter and the
// writeback sources that feed it.
//   RF_AW / RF_DW  : default register address / data widths
//   RF_GW          : width of the grant index exported by the arbiter
//   RF_ZERO        : hard-wired zero register; writes to it are dropped
//   REQ_WB/MDU/LSU : requester slot assignment of the writeback sources
// -----------------------------------------------------------------------------
package rf_write_arbiter_pkg;

  localparam int RF_AW = 5;
  localparam int RF_DW = 32;
  localparam int RF_GW = 3;

  localparam logic [RF_AW-1:0] RF_ZERO = '0;

  localparam int REQ_WB  = 0;
  localparam int REQ_MDU = 1;
  localparam int REQ_LSU = 2;

  // Round-robin successor of slot v among n slots.
  function automatic logic [RF_GW-1:0] rr_next(input logic [RF_GW-1:0] v, input int n);
    rr_next = (int'(v) >= n - 1) ? '0 : v + 1'b1;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter_if
// Request side of the write-port arbiter: one valid/ready channel per
// writeback source, with addresses and data packed side by side.
//   req_valid [N_REQ]      : requester i has a write to hand over
//   req_ready [N_REQ]      : arbiter slot i can take it this edge
//   req_addr  [N_REQ*AW]   : destination register, requester i at [i*AW +: AW]
//   req_data  [N_REQ*DW]   : write data, requester i at [i*DW +: DW]
// master = writeback sources, slave = arbiter.
// -----------------------------------------------------------------------------
interface rf_write_arbiter_if #(
  parameter int N_REQ = 3,
  parameter int AW    = 5,
  parameter int DW    = 32
);

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*DW-1:0] req_data;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/rf_write_arbiter_picker.sv
// -----------------------------------------------------------------------------
// rr_age_picker
// Purely combinational oldest-first picker with round-robin tie-break.
// A slot is a candidate when it is full and no other full slot is older
// than it; among candidates the first one at or after the RR pointer wins.
//   i_full    [N]      : slot occupancy
//   i_old     [N][N]   : i_old[i][j]=1 -> slot i filled strictly before slot j
//   i_rr      [IW]     : round-robin start index (must be < N)
//   o_gnt     [N]      : one-hot grant
//   o_gnt_idx [IW]     : grant index (0 when nothing granted)
//   o_gnt_vld          : some slot granted
// -----------------------------------------------------------------------------
module rr_age_picker
  import rf_write_arbiter_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = RF_GW
) (
  input  logic [N-1:0]        i_full,
  input  logic [N-1:0][N-1:0] i_old,
  input  logic [IW-1:0]       i_rr,
  output logic [N-1:0]        o_gnt,
  output logic [IW-1:0]       o_gnt_idx,
  output logic                o_gnt_vld
);

  logic [N-1:0] w_cand;

  // Column i of the age matrix lists who is older than slot i.
  always_comb begin
    w_cand = '0;
    for (int i = 0; i < N; i++) begin
      w_cand[i] = i_full[i];
      for (int k = 0; k < N; k++) begin
        if (i_full[k] && i_old[k][i]) w_cand[i] = 1'b0;
      end
    end
  end

  always_comb begin
    int   idx;
    logic found;
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_gnt_vld = 1'b0;
    found     = 1'b0;
    idx       = 0;
    for (int off = 0; off < N; off++) begin
      idx = int'(i_rr) + off;
      if (idx >= N) idx = idx - N;
      if (!found && w_cand[idx]) begin
        found      = 1'b1;
        o_gnt[idx] = 1'b1;
        o_gnt_idx  = IW'(idx);
      end
    end
    o_gnt_vld = found;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter
// Shares the register file's single write port between several writeback
// sources. Each source owns a one-entry holding slot; slots drain one per
// cycle, oldest first, round-robin among equally old slots. The register
// file commits rf_we/rf_wr/rf_din on the falling edge of the same cycle.
//   clk        : slot state updates on the rising edge
//   rst_n      : asynchronous active-low reset, drops all held writes
//   bus        : per-requester valid/ready/addr/data (slave side)
//   rf_we      : register file write enable
//   rf_wr      : register file write address
//   rf_din     : register file write data
//   grant_id   : slot being drained (valid when rf_we=1, else 0)
//   pend_mask  : bit r set while any full slot targets register r
// -----------------------------------------------------------------------------
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int AW    = RF_AW,
  parameter int DW    = RF_DW
) (
  input  logic                clk,
  input  logic                rst_n,
  rf_write_arbiter_if.slave   bus,
  output logic                rf_we,
  output logic [AW-1:0]       rf_wr,
  output logic [DW-1:0]       rf_din,
  output logic [RF_GW-1:0]    grant_id,
  output logic [2**AW-1:0]    pend_mask
);

  logic [N_REQ-1:0]             r_full;
  logic [N_REQ-1:0][N_REQ-1:0]  r_old;
  logic [RF_GW-1:0]             r_rr;
  logic [N_REQ-1:0][AW-1:0]     r_addr;
  logic [N_REQ-1:0][DW-1:0]     r_data;

  logic [N_REQ-1:0]  w_gnt;
  logic [RF_GW-1:0]  w_gnt_idx;
  logic              w_gnt_vld;
  logic [N_REQ-1:0]  w_ready;
  logic [N_REQ-1:0]  w_acc;
  logic [N_REQ-1:0]  w_fill;

  rr_age_picker #(
    .N  (N_REQ),
    .IW (RF_GW)
  ) u_picker (
    .i_full    (r_full),
    .i_old     (r_old),
    .i_rr      (r_rr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_gnt_vld (w_gnt_vld)
  );

  // A draining slot can be refilled on the same edge, so ready comes only
  // from registered state and never from the request inputs.
  assign w_ready       = ~r_full | w_gnt;
  assign bus.req_ready = w_ready;
  assign w_acc         = bus.req_valid & w_ready;

  // Writes to the zero register complete the handshake but are never held.
  always_comb begin
    w_fill = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_fill[i] = w_acc[i] && (bus.req_addr[i*AW +: AW] != AW'(RF_ZERO));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= '0;
      r_old  <= '0;
      r_rr   <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (w_fill[i])                 r_full[i] <= 1'b1;
        else if (w_acc[i] || w_gnt[i]) r_full[i] <= 1'b0;
      end
      // A fresh fill is younger than every slot that stays full across this
      // edge; slots filled on the same edge end up mutually not older.
      for (int j = 0; j < N_REQ; j++) begin
        if (w_fill[j]) begin
          for (int k = 0; k < N_REQ; k++) begin
            if (k != j) begin
              r_old[k][j] <= r_full[k] & ~w_gnt[k];
              r_old[j][k] <= 1'b0;
            end
          end
        end
      end
      if (w_gnt_vld) r_rr <= rr_next(w_gnt_idx, N_REQ);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (w_fill[i]) begin
        r_addr[i] <= bus.req_addr[i*AW +: AW];
        r_data[i] <= bus.req_data[i*DW +: DW];
      end
    end
  end

  // Write port mux: the grant is one-hot, so an AND-OR select suffices and
  // forces zeros on the bus when nothing is granted.
  always_comb begin
    rf_wr  = '0;
    rf_din = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt[i]) begin
        rf_wr  = rf_wr  | r_addr[i];
        rf_din = rf_din | r_data[i];
      end
    end
  end

  assign rf_we    = w_gnt_vld;
  assign grant_id = w_gnt_idx;

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_full[i]) pend_mask[r_addr[i]] = 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rf_write_arbiter_if #(.N_REQ(N), .AW(AW), .DW(DW)) bus ();

  logic          rf_we;
  logic [AW-1:0] rf_wr;
  logic [DW-1:0] rf_din;
  logic [2:0]    grant_id;
  logic [31:0]   pend_mask;

  rf_write_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .rf_we     (rf_we),
    .rf_wr     (rf_wr),
    .rf_din    (rf_din),
    .grant_id  (grant_id),
    .pend_mask (pend_mask)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model: each slot remembers the cycle stamp of its fill; the
  // oldest stamp wins, ties broken by scanning from the RR pointer.
  bit            m_full [N];
  logic [AW-1:0] m_addr [N];
  logic [DW-1:0] m_data [N];
  longint        m_ts   [N];
  int            m_rr;
  longint        stamp = 0;

  logic [DW-1:0] mrf [32];
  logic [DW-1:0] drf [32];
  int            zero_writes = 0;
  int            n_writes = 0;
  logic [DW-1:0] r7_log [$];

  logic          obs_we;
  logic [AW-1:0] obs_wr;
  logic [DW-1:0] obs_din;
  logic [2:0]    obs_gid;
  logic [31:0]   obs_pend;
  logic [N-1:0]  obs_ready;

  function automatic int model_pick();
    longint best;
    int     i;
    best = 64'h7fff_ffff_ffff_ffff;
    for (int k = 0; k < N; k++) if (m_full[k] && m_ts[k] < best) best = m_ts[k];
    for (int off = 0; off < N; off++) begin
      i = (m_rr + off) % N;
      if (m_full[i] && m_ts[i] == best) return i;
    end
    return -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) m_full[i] = 1'b0;
    m_rr = 0;
  endtask

  task automatic drive(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid[i]         = v;
    bus.req_addr[i*AW +: AW] = a;
    bus.req_data[i*DW +: DW] = d;
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) drive(i, 1'b0, '0, '0);
  endtask

  // One clock cycle: compare at the falling edge, advance the model at the
  // rising edge, return 1 time unit after it.
  task automatic cycle();
    int            g;
    logic [AW-1:0] ew;
    logic [DW-1:0] ed;
    logic [31:0]   ep;
    logic [N-1:0]  er;
    logic [N-1:0]  acc;
    @(negedge clk);
    g  = model_pick();
    ew = '0;
    ed = '0;
    ep = '0;
    for (int i = 0; i < N; i++) begin
      if (m_full[i]) ep[m_addr[i]] = 1'b1;
      er[i] = !m_full[i] || (i == g);
    end
    if (g >= 0) begin
      ew = m_addr[g];
      ed = m_data[g];
    end
    check_eq("rf_we",     64'(rf_we),         64'(g >= 0));
    check_eq("rf_wr",     64'(rf_wr),         64'(ew));
    check_eq("rf_din",    64'(rf_din),        64'(ed));
    check_eq("grant_id",  64'(grant_id),      64'((g >= 0) ? g : 0));
    check_eq("pend_mask", 64'(pend_mask),     64'(ep));
    check_eq("req_ready", 64'(bus.req_ready), 64'(er));
    obs_we    = rf_we;
    obs_wr    = rf_wr;
    obs_din   = rf_din;
    obs_gid   = grant_id;
    obs_pend  = pend_mask;
    obs_ready = bus.req_ready;
    if (rf_we) begin
      drf[rf_wr] = rf_din;
      n_writes++;
      if (rf_wr == '0) zero_writes++;
      if (rf_wr == AW'(7)) r7_log.push_back(rf_din);
    end
    if (g >= 0) mrf[m_addr[g]] = m_data[g];
    acc = bus.req_valid & er;
    @(posedge clk);
    stamp++;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        if (bus.req_addr[i*AW +: AW] != '0) begin
          m_full[i] = 1'b1;
          m_addr[i] = bus.req_addr[i*AW +: AW];
          m_data[i] = bus.req_data[i*DW +: DW];
          m_ts[i]   = stamp;
        end else begin
          m_full[i] = 1'b0;
        end
      end else if (i == g) begin
        m_full[i] = 1'b0;
      end
    end
    if (g >= 0) m_rr = (g + 1) % N;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wb;
    for (int r = 0; r < 32; r++) begin
      mrf[r] = '0;
      drf[r] = '0;
    end
    idle_all();
    model_clear();

    // Reset then idle
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_we",    64'(rf_we),         64'(0));
    check_eq("rst_wr",    64'(rf_wr),         64'(0));
    check_eq("rst_din",   64'(rf_din),        64'(0));
    check_eq("rst_gid",   64'(grant_id),      64'(0));
    check_eq("rst_pend",  64'(pend_mask),     64'(0));
    check_eq("rst_ready", 64'(bus.req_ready), 64'(3'b111));
    rst_n = 1'b1;
    repeat (4) cycle();
    check_eq("idle_ready", 64'(obs_ready), 64'(3'b111));

    // Single write
    drive(0, 1'b1, AW'(5), 32'hDEAD_BEEF);
    cycle();
    drive(0, 1'b0, '0, '0);
    cycle();
    check_eq("single_we",   64'(obs_we),   64'(1));
    check_eq("single_wr",   64'(obs_wr),   64'(5));
    check_eq("single_din",  64'(obs_din),  64'(32'hDEAD_BEEF));
    check_eq("single_pend", 64'(obs_pend), 64'(32'h0000_0020));
    cycle();
    check_eq("single_we_after",   64'(obs_we),   64'(0));
    check_eq("single_pend_after", 64'(obs_pend), 64'(0));

    // Contention and fairness
    do_reset();
    for (int i = 0; i < N; i++) drive(i, 1'b1, AW'(i + 1), 32'(32'h100 + i));
    for (int t = 0; t < 10; t++) begin
      cycle();
      if (t == 0) begin
        check_eq("cont_we0",    64'(obs_we),    64'(0));
        check_eq("cont_ready0", 64'(obs_ready), 64'(3'b111));
      end else begin
        check_eq("cont_we",    64'(obs_we),    64'(1));
        check_eq("cont_gid",   64'(obs_gid),   64'((t - 1) % 3));
        check_eq("cont_ready", 64'(obs_ready), 64'(3'b001 << ((t - 1) % 3)));
      end
    end
    idle_all();
    repeat (N + 1) cycle();

    // Ordering of two writes to r7 from different requesters
    do_reset();
    r7_log.delete();
    drive(1, 1'b1, AW'(7), 32'h11);
    cycle();
    drive(1, 1'b0, '0, '0);
    drive(0, 1'b1, AW'(7), 32'h22);
    cycle();
    drive(0, 1'b0, '0, '0);
    repeat (3) cycle();
    check_eq("order_count",  64'(r7_log.size()), 64'(2));
    if (r7_log.size() == 2) begin
      check_eq("order_first",  64'(r7_log[0]), 64'(32'h11));
      check_eq("order_second", 64'(r7_log[1]), 64'(32'h22));
    end
    check_eq("order_r7", 64'(drf[7]), 64'(32'h22));

    // Zero register
    zero_writes = 0;
    drive(2, 1'b1, '0, 32'hFFFF_FFFF);
    cycle();
    check_eq("zero_ready", 64'(obs_ready[2]), 64'(1));
    drive(2, 1'b0, '0, '0);
    repeat (2) begin
      cycle();
      check_eq("zero_we",   64'(obs_we),   64'(0));
      check_eq("zero_pend", 64'(obs_pend), 64'(0));
    end

    // Randomized traffic against the model
    do_reset();
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++)
        drive(i, ($urandom_range(0, 3) != 0), AW'($urandom_range(0, 31)), $urandom);
      cycle();
    end
    idle_all();
    repeat (N + 2) cycle();
    for (int r = 0; r < 32; r++) check_eq($sformatf("rf_r%0d", r), 64'(drf[r]), 64'(mrf[r]));
    check_eq("zero_writes", 64'(zero_writes), 64'(0));

    // Reset mid-flight
    for (int i = 0; i < N; i++) drive(i, 1'b1, AW'(i + 4), 32'(32'hA0 + i));
    cycle();
    idle_all();
    wb = n_writes;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_we",    64'(rf_we),         64'(0));
    check_eq("mid_rst_pend",  64'(pend_mask),     64'(0));
    check_eq("mid_rst_ready", 64'(bus.req_ready), 64'(3'b111));
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) cycle();
    check_eq("mid_rst_no_write", 64'(n_writes), 64'(wb));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
